// File: rtl/wb_ram_pkg.sv
// Shared types and default widths for the two-master Wishbone RAM arbiter.
package wb_ram_pkg;

  localparam int ADR_WIDTH_DEF = 16;
  localparam int DAT_WIDTH_DEF = 16;
  localparam int MAX_BURST_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

  function automatic owner_t own_of(input port_t p);
    return p ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/wb_ram_arbiter.sv
// Shares one single-port sync RAM between two pipelined Wishbone masters; accept in N, ack in N+1.
// The losing master is stalled combinationally; an owner keeps at most MAX_BURST transfers under contention.
module wb_ram_arbiter
  import wb_ram_pkg::*;
#(
  parameter int ADR_WIDTH = ADR_WIDTH_DEF,
  parameter int DAT_WIDTH = DAT_WIDTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [ADR_WIDTH-1:0] m0_adr,
  input  logic [DAT_WIDTH-1:0] m0_dat_w,
  output logic [DAT_WIDTH-1:0] m0_dat_r,
  output logic                 m0_ack,
  output logic                 m0_stall,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [ADR_WIDTH-1:0] m1_adr,
  input  logic [DAT_WIDTH-1:0] m1_dat_w,
  output logic [DAT_WIDTH-1:0] m1_dat_r,
  output logic                 m1_ack,
  output logic                 m1_stall,
  output logic [ADR_WIDTH-1:0] ram_a,
  output logic [DAT_WIDTH-1:0] ram_d,
  output logic                 ram_cen,
  output logic                 ram_wen,
  input  logic [DAT_WIDTH-1:0] ram_q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  owner_t          owner_q, owner_d;
  port_t           last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ack_q;
  logic            r0, r1, win0, win1, at_lim;

  assign r0     = m0_cyc & m0_stb;
  assign r1     = m1_cyc & m1_stb;
  assign at_lim = (cnt_q == CNT_MAX);

  always_comb begin
    win0    = 1'b0;
    win1    = 1'b0;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    // A live owner keeps the RAM until its burst limit is hit under contention.
    if (owner_q == OWN0 && m0_cyc) begin
      if (at_lim && r1) win1 = 1'b1;
      else if (r0)      win0 = 1'b1;
    end else if (owner_q == OWN1 && m1_cyc) begin
      if (at_lim && r0) win0 = 1'b1;
      else if (r1)      win1 = 1'b1;
    end else if (r0 && r1) begin
      if (last_q == PORT1) win0 = 1'b1;
      else                 win1 = 1'b1;
    end else begin
      win0 = r0;
      win1 = r1;
    end

    if (win0 | win1) begin
      last_d = win1;
      if (owner_q != own_of(win1)) begin
        owner_d = own_of(win1);
        cnt_d   = CW'(1);
      end else if (!at_lim) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if ((owner_q == OWN0 && !m0_cyc) || (owner_q == OWN1 && !m1_cyc)) begin
      owner_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= IDLE;
      last_q  <= PORT1;
      cnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= {win1, win0};
    end
  end

  assign ram_cen  = win0 | win1;
  assign ram_wen  = (win0 & m0_we) | (win1 & m1_we);
  assign ram_a    = win1 ? m1_adr : m0_adr;
  assign ram_d    = win1 ? m1_dat_w : m0_dat_w;

  // Gating with cyc makes an abort drop the ack that was already in flight.
  assign m0_ack   = ack_q[0] & m0_cyc;
  assign m1_ack   = ack_q[1] & m1_cyc;
  assign m0_stall = r0 & ~win0;
  assign m1_stall = r1 & ~win1;
  assign m0_dat_r = ram_q;
  assign m1_dat_r = ram_q;

endmodule
